// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory with byte/half/word stores, extended loads
// and configurable wait states. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.

module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        misaligned
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic HAS_WAIT = (WAIT_CYCLES != 0);

    localparam logic [3:0] LD_LB  = 4'b0000;
    localparam logic [3:0] LD_LH  = 4'b0001;
    localparam logic [3:0] LD_LBU = 4'b0011;
    localparam logic [3:0] LD_LHU = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             req_rd_q;
    logic [3:0]       req_mask_q;
    logic [IDX_W-1:0] req_idx_q;
    logic [1:0]       req_lo_q;
    logic [31:0]      req_wdata_q;

    logic             accept;
    logic             exec;
    logic             op_rd;
    logic [3:0]       op_mask;
    logic [IDX_W-1:0] op_idx;
    logic [1:0]       op_lo;
    logic [31:0]      op_wdata;

    logic [31:0]      mem_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_val;
    logic [3:0]       lane_en;
    logic [31:0]      lane_data;
    logic             acc_mis;
    logic             we;
    logic [31:0]      rdata_d;
    logic             rvalid_d;
    logic             mis_d;

    logic [31:0]      mem [DEPTH_WORDS];

    // Address bits above the array size alias silently onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    // Next-state: accept in IDLE/RESP, count wait states in BUSY, execute when the count expires.
    always_comb begin : fsm_next
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        exec    = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (!cs) begin
                    accept = 1'b1;
                    if (HAS_WAIT) begin
                        cnt_d   = WAIT_INIT;
                        state_d = BUSY;
                    end else begin
                        exec    = 1'b1;
                        state_d = rd ? RESP : IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    exec    = 1'b1;
                    cnt_d   = '0;
                    state_d = req_rd_q ? RESP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Zero-wait accesses execute straight from the bus; delayed ones use the captured request.
    always_comb begin : operand_sel
        op_rd    = rd;
        op_mask  = mask;
        op_idx   = addr[IDX_W+1:2];
        op_lo    = addr[1:0];
        op_wdata = wdata;
        if (state_q == BUSY) begin
            op_rd    = req_rd_q;
            op_mask  = req_mask_q;
            op_idx   = req_idx_q;
            op_lo    = req_lo_q;
            op_wdata = req_wdata_q;
        end
    end

    // Store data is right-justified; replicate it so each enabled lane sees its slice.
    always_comb begin : store_lanes
        lane_en   = 4'b0000;
        lane_data = op_wdata;
        case (op_mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                lane_en   = op_mask;
                lane_data = {4{op_wdata[7:0]}};
            end
            4'b0011, 4'b1100: begin
                lane_en   = op_mask;
                lane_data = {2{op_wdata[15:0]}};
            end
            4'b1111: begin
                lane_en   = op_mask;
                lane_data = op_wdata;
            end
            default: lane_en = 4'b0000;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic acc_half;
    logic acc_word;

    always_comb begin : misalign_chk
        acc_half = 1'b0;
        acc_word = 1'b0;
        acc_mis  = 1'b0;
        if (op_rd) begin
            acc_half = (op_mask == LD_LH) || (op_mask == LD_LHU);
            acc_word = !((op_mask == LD_LB) || (op_mask == LD_LH) ||
                         (op_mask == LD_LBU) || (op_mask == LD_LHU));
        end else begin
            acc_half = (op_mask == 4'b0011) || (op_mask == 4'b1100);
            acc_word = (op_mask == 4'b1111);
        end
        acc_mis = (acc_half && op_lo[0]) || (acc_word && (op_lo != 2'b00));
    end
`else
    always_comb begin : misalign_chk
        acc_mis = 1'b0;
    end
`endif

    always_comb begin : load_ext
        mem_word = mem[op_idx];
        ld_byte  = mem_word[{op_lo, 3'b000} +: 8];
        ld_half  = op_lo[1] ? mem_word[31:16] : mem_word[15:0];
        ld_val   = mem_word;
        case (op_mask)
            LD_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            LD_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            LD_LBU:  ld_val = {24'd0, ld_byte};
            LD_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = mem_word;
        endcase
    end

    // rdata only moves on a load execution, so a request accepted in RESP leaves it intact.
    always_comb begin : resp_next
        rdata_d  = rdata;
        mis_d    = 1'b0;
        we       = 1'b0;
        if (exec) begin
            mis_d = acc_mis;
            if (op_rd) begin
                rdata_d = acc_mis ? 32'd0 : ld_val;
            end else begin
                we = rst_n && !acc_mis && (lane_en != 4'b0000);
            end
        end
        rvalid_d = (state_d == RESP);
    end

    always_comb begin : stall_gen
        stall = rst_n && ((state_q == BUSY) ||
                (((state_q == IDLE) || (state_q == RESP)) && !cs && HAS_WAIT));
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
            misaligned  <= 1'b0;
            req_rd_q    <= 1'b0;
            req_mask_q  <= '0;
            req_idx_q   <= '0;
            req_lo_q    <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata      <= rdata_d;
            rvalid     <= rvalid_d;
            misaligned <= mis_d;
            if (accept) begin
                req_rd_q    <= rd;
                req_mask_q  <= mask;
                req_idx_q   <= addr[IDX_W+1:2];
                req_lo_q    <= addr[1:0];
                req_wdata_q <= wdata;
            end
        end
    end

    // Array is never reset.
    always_ff @(posedge clk) begin : mem_write
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[op_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

endmodule
